// File: rtl/wb_arb.sv
// Write-back arbiter: merges the non-stallable EX result with a FIFO-buffered
// long-latency result stream onto the single register-file write port.
module wb_arb #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [4:0]    ex_rd,
  input  logic [DW-1:0] ex_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [4:0]    lsu_rd,
  input  logic [DW-1:0] lsu_data,
  input  logic          issue_en,
  input  logic [4:0]    issue_rd,
  output logic [31:0]   busy_mask,
  output logic          waw_err,
  output logic          wr_en,
  output logic [4:0]    wr_addr,
  output logic [DW-1:0] wr_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [DW-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic          waw_q;
  logic          wr_en_q;
  logic [4:0]    wr_addr_q;
  logic [DW-1:0] wr_data_q;

  logic          push, pop;
  logic [4:0]    head_rd;
  logic [DW-1:0] head_data;

  // Ready comes from the registered count only, so a same-edge pop never frees a slot early.
  assign lsu_ready = (count_q < FULL);
  assign push      = lsu_valid && lsu_ready;
  assign pop       = !ex_valid && (count_q != '0);
  assign head_rd   = fifo_rd_q[rptr_q];
  assign head_data = fifo_data_q[rptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear on pop is applied before set on issue so a same-edge re-issue keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_rd] = 1'b0;
    if (issue_en && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= lsu_rd;
      fifo_data_q[wptr_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      waw_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
      busy_q  <= busy_d;
      if (ex_valid && (ex_rd != '0) && busy_q[ex_rd]) waw_q <= 1'b1;
      if (ex_valid) begin
        wr_en_q   <= (ex_rd != '0);
        wr_addr_q <= ex_rd;
        wr_data_q <= ex_data;
      end else if (pop) begin
        wr_en_q   <= (head_rd != '0);
        wr_addr_q <= head_rd;
        wr_data_q <= head_data;
      end else begin
        wr_en_q <= 1'b0;
      end
    end
  end

  assign busy_mask = busy_q;
  assign waw_err   = waw_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
